// File: rtl/icache_line_filler_pkg.sv
// rtl/icache_line_filler_pkg.sv - shared constants and state encoding for the line filler
package icache_line_filler_pkg;

    localparam int WORD_BITS        = 32;
    localparam int BYTE_OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } fill_state_e;

    // Mask that clears the in-line offset bits of a byte address.
    function automatic logic [WORD_BITS-1:0] line_mask(input int num_blocks);
        line_mask = ~((WORD_BITS'(num_blocks) << BYTE_OFFSET_BITS) - WORD_BITS'(1));
    endfunction

endpackage

// File: rtl/icache_line_filler_if.sv
// rtl/icache_line_filler_if.sv - line request and narrow memory bus bundle
interface icache_line_filler_if #(
    parameter int NUM_BLOCKS = 4
);
    import icache_line_filler_pkg::*;

    logic                              line_req_valid;
    logic [WORD_BITS-1:0]              line_req_addr;
    logic                              line_req_ready;
    logic [WORD_BITS*NUM_BLOCKS-1:0]   line_rdata;
    logic                              mem_valid;
    logic                              mem_instr;
    logic [WORD_BITS-1:0]              mem_addr;
    logic                              mem_ready;
    logic [WORD_BITS-1:0]              mem_rdata;
    logic                              busy;

    // Filler side: serves the cache, drives the memory bus.
    modport master (
        input  line_req_valid, line_req_addr, mem_ready, mem_rdata,
        output line_req_ready, line_rdata, mem_valid, mem_instr, mem_addr, busy
    );

    // Environment side: the cache and the memory together.
    modport slave (
        output line_req_valid, line_req_addr, mem_ready, mem_rdata,
        input  line_req_ready, line_rdata, mem_valid, mem_instr, mem_addr, busy
    );

endinterface

// File: rtl/icache_line_filler.sv
// rtl/icache_line_filler.sv - splits one cache line fill into sequential 32-bit reads
module icache_line_filler
    import icache_line_filler_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    icache_line_filler_if.master  bus
);

    localparam int                   BEAT_BITS = $clog2(NUM_BLOCKS);
    localparam int                   SLOT_BITS = BLOCK_SIZE * 8;
    localparam int                   LINE_BITS = SLOT_BITS * NUM_BLOCKS;
    localparam logic [WORD_BITS-1:0] LINE_MASK = line_mask(NUM_BLOCKS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NUM_BLOCKS - 1);

    fill_state_e          state_q;
    logic [BEAT_BITS-1:0] beat_q;
    logic [WORD_BITS-1:0] base_q;
    logic                 abort_q;
    logic                 mem_valid_q;
    logic [WORD_BITS-1:0] mem_addr_q;
    logic [LINE_BITS-1:0] line_q;
    logic                 ready_q;

    logic                 abort_d;
    logic [WORD_BITS-1:0] next_addr_d;

    // Sticky abort view for this edge and the address of the beat about to issue.
    always_comb begin
        abort_d     = abort_q | ~bus.line_req_valid;
        next_addr_d = base_q | (WORD_BITS'(beat_q) << BYTE_OFFSET_BITS);
    end

    // Fill sequencer: issue beats, capture words, drain on abandon, pulse ready at the end.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            abort_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            line_q      <= '0;
            ready_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (bus.line_req_valid) begin
                        base_q      <= bus.line_req_addr & LINE_MASK;
                        mem_addr_q  <= bus.line_req_addr & LINE_MASK;
                        beat_q      <= '0;
                        mem_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    abort_q <= abort_d;
                    if (bus.mem_ready) begin
                        // An abandoned fill still lands here; the slot is simply never returned.
                        line_q[int'(beat_q)*SLOT_BITS +: SLOT_BITS] <= bus.mem_rdata;
                        mem_valid_q <= 1'b0;
                        if (abort_d) begin
                            state_q <= ST_IDLE;
                        end else if (beat_q == LAST_BEAT) begin
                            ready_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    abort_q <= abort_d;
                    if (abort_d) begin
                        state_q <= ST_IDLE;
                    end else begin
                        mem_addr_q  <= next_addr_d;
                        mem_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.line_req_ready = ready_q;
    assign bus.line_rdata     = line_q;
    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_instr      = mem_valid_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icache_line_filler.sv
// tb/tb_icache_line_filler.sv - scoreboard bench for icache_line_filler
module tb_icache_line_filler;

    localparam int          NB    = 4;
    localparam int          LW    = 32 * NB;
    localparam logic [31:0] LMASK = ~32'(NB * 4 - 1);

    typedef struct {
        logic [LW-1:0] line;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    exp_t        exp_q[$];
    logic [31:0] ea_q[$];
    int          wq[$];

    icache_line_filler_if #(.NUM_BLOCKS(NB)) bus ();

    icache_line_filler #(.NUM_BLOCKS(NB), .BLOCK_SIZE(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h1230 && a <= 32'h123C) return 32'h11 * ((a - 32'h1230) / 4 + 1);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [31:0] a);
        logic [LW-1:0] r;
        logic [31:0]   base;
        base = a & LMASK;
        r = '0;
        for (int k = 0; k < NB; k++) r[32*k +: 32] = mem_word(base + 32'(4 * k));
        return r;
    endfunction

    // Memory model: per-beat wait counts come from wq; checks addresses and bus rules.
    initial begin : mem_model
        bit          loaded;
        int          remaining;
        logic [31:0] beat_addr;
        loaded = 0;
        remaining = 0;
        beat_addr = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            chk("mem_instr", LW'(bus.mem_instr), LW'(bus.mem_valid));
            bus.mem_rdata = $urandom;
            if (!resetn) begin
                loaded = 0;
                bus.mem_ready = 1'b0;
            end else if (!bus.mem_valid) begin
                if (loaded) chk("mem_valid_held", LW'(bus.mem_valid), LW'(1));
                loaded = 0;
                bus.mem_ready = 1'b0;
            end else begin
                if (!loaded) begin
                    loaded = 1;
                    beat_addr = bus.mem_addr;
                    remaining = (wq.size() > 0) ? wq.pop_front() : 0;
                    chk("mem_beat_expected", LW'(ea_q.size() > 0), LW'(1));
                    if (ea_q.size() > 0) chk("mem_addr", LW'(bus.mem_addr), LW'(ea_q.pop_front()));
                end else begin
                    chk("mem_addr_stable", LW'(bus.mem_addr), LW'(beat_addr));
                end
                if (remaining > 0) begin
                    remaining--;
                    bus.mem_ready = 1'b0;
                end else begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    hs_cnt++;
                    loaded = 0;
                end
            end
        end
    end

    // Line monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin : line_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.line_req_ready) begin
                chk("ready_expected", LW'(exp_q.size() > 0), LW'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("line_rdata", bus.line_rdata, e.line);
                    if (e.cyc >= 0) chk("ready_latency", LW'(cyc), LW'(e.cyc));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.line_req_ready && n < 400);
        chk("fill_done", LW'(bus.line_req_ready), LW'(1));
        bus.line_req_valid = 1'b0;
    endtask

    task automatic wait_beat(input logic [31:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_valid && bus.mem_addr == a) && n < 200);
        chk("beat_reached", LW'(bus.mem_valid && bus.mem_addr == a), LW'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", LW'(bus.busy), LW'(0));
    endtask

    // wmode >= 0: every beat waits wmode cycles; wmode < 0: random 0..3 per beat.
    task automatic do_fill(input logic [31:0] addr, input int wmode);
        exp_t        e;
        int          sum;
        int          w;
        logic [31:0] base;
        sum  = 0;
        base = addr & LMASK;
        @(negedge clk);
        for (int k = 0; k < NB; k++) begin
            w = (wmode >= 0) ? wmode : int'($urandom_range(0, 3));
            wq.push_back(w);
            sum += w;
            ea_q.push_back(base + 32'(4 * k));
        end
        e.line = ref_line(addr);
        e.cyc  = cyc + 2 * NB + sum;
        exp_q.push_back(e);
        bus.line_req_valid = 1'b1;
        bus.line_req_addr  = addr;
        wait_ready();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          hs0;
        exp_t        e;
        logic [LW-1:0] held;

        resetn = 1'b0;
        bus.line_req_valid = 1'b0;
        bus.line_req_addr  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",     LW'(bus.line_req_ready), LW'(0));
        chk("rst_mem_valid", LW'(bus.mem_valid),      LW'(0));
        chk("rst_busy",      LW'(bus.busy),           LW'(0));
        chk("rst_mem_addr",  LW'(bus.mem_addr),       LW'(0));
        chk("rst_line",      bus.line_rdata,          LW'(0));
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait fill of the known 0x1230 line.
        hs0 = hs_cnt;
        do_fill(32'h0000_1230, 0);
        chk("zw_line_value", bus.line_rdata, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("zw_handshakes", LW'(hs_cnt - hs0), LW'(NB));

        // Three wait states per beat.
        hs0 = hs_cnt;
        do_fill(32'h8000_0040, 3);
        chk("ws_handshakes", LW'(hs_cnt - hs0), LW'(NB));

        // Abandon during beat 1 while memory stalls; beat completes, nothing more follows.
        hs0 = hs_cnt;
        @(negedge clk);
        wq.push_back(0); wq.push_back(5);
        ea_q.push_back(32'h3000); ea_q.push_back(32'h3004);
        bus.line_req_valid = 1'b1;
        bus.line_req_addr  = 32'h3000;
        wait_beat(32'h3004);
        bus.line_req_valid = 1'b0;
        wait_idle();
        chk("abort_handshakes", LW'(hs_cnt - hs0), LW'(2));
        chk("abort_ready",      LW'(bus.line_req_ready), LW'(0));
        repeat (5) @(negedge clk);
        chk("abort_no_beat2",   LW'(bus.mem_valid), LW'(0));
        chk("abort_busy",       LW'(bus.busy), LW'(0));
        chk("abort_hs_final",   LW'(hs_cnt - hs0), LW'(2));

        // Abandon then re-request 0x2000 during the drain.
        hs0 = hs_cnt;
        @(negedge clk);
        wq.push_back(0); wq.push_back(4);
        ea_q.push_back(32'h4000); ea_q.push_back(32'h4004);
        for (int k = 0; k < NB; k++) begin
            wq.push_back(0);
            ea_q.push_back(32'h2000 + 32'(4 * k));
        end
        e.line = ref_line(32'h2000);
        e.cyc  = -1;
        exp_q.push_back(e);
        bus.line_req_valid = 1'b1;
        bus.line_req_addr  = 32'h4000;
        wait_beat(32'h4004);
        bus.line_req_valid = 1'b0;
        @(negedge clk);
        bus.line_req_valid = 1'b1;
        bus.line_req_addr  = 32'h2000;
        wait_ready();
        chk("redo_handshakes", LW'(hs_cnt - hs0), LW'(2 + NB));

        // Reset in the middle of beat 2.
        @(negedge clk);
        wq.push_back(0); wq.push_back(0); wq.push_back(10);
        ea_q.push_back(32'h6000); ea_q.push_back(32'h6004); ea_q.push_back(32'h6008);
        bus.line_req_valid = 1'b1;
        bus.line_req_addr  = 32'h6000;
        wait_beat(32'h6008);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_mem_valid", LW'(bus.mem_valid),      LW'(0));
        chk("midrst_ready",     LW'(bus.line_req_ready), LW'(0));
        chk("midrst_busy",      LW'(bus.busy),           LW'(0));
        bus.line_req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_fill(32'h0000_7000, 1);

        // Back-to-back fills; the line holds steady after the pulse.
        do_fill(32'h0000_0100, 0);
        held = ref_line(32'h0000_0100);
        @(negedge clk);
        chk("line_held", bus.line_rdata, held);
        do_fill(32'h0000_0200, -1);

        // Random fills, including the top line and unaligned request addresses.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_fill((i == 0) ? 32'hFFFF_FFF0 : 32'($urandom), -1);
        end

        repeat (4) @(negedge clk);
        chk("end_busy",       LW'(bus.busy),     LW'(0));
        chk("end_addr_queue", LW'(ea_q.size()),  LW'(0));
        chk("end_line_queue", LW'(exp_q.size()), LW'(0));
        chk("end_wait_queue", LW'(wq.size()),    LW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
